// File: rtl/pipeline_issue_controller.sv
// pipeline_issue_controller
// Issue/hazard sequencer between fetch and decode of the 8-bit pipelined core.
// Accepts one instruction per cycle, tracks pending register writes in a
// 4-entry countdown scoreboard, stalls fetch on RAW/WAW hazards, drains the
// pipe on HALT and counts hazard-stalled cycles (saturating).
// Instruction word: [7:6] op (ADD/SUB/LOAD/HALT), [5:4] rd, [3:2] rs1, [1:0] rs2.

module pipeline_issue_controller #(
    parameter int ALU_LAT  = 1,   // cycles before an ADD/SUB result is consumable
    parameter int LOAD_LAT = 2,   // cycles before a LOAD result is consumable
    parameter int CNT_W    = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    output logic             instr_ready,
    output logic             issue_valid,
    output logic [1:0]       issue_op,
    output logic [1:0]       issue_rd,
    output logic [1:0]       issue_rs1,
    output logic [1:0]       issue_rs2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stall_cycles
);

    // Scoreboard entries must hold LOAD_LAT; keep at least one bit when LOAD_LAT is 0.
    localparam int              SB_W      = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
    localparam logic [SB_W-1:0] ALU_CNT   = SB_W'(ALU_LAT);
    localparam logic [SB_W-1:0] LOAD_CNT  = SB_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    state_e           state_q;
    logic [SB_W-1:0]  cnt_q [4];
    logic [SB_W-1:0]  cnt_d [4];
    logic             issue_valid_q;
    logic [1:0]       issue_op_q;
    logic [1:0]       issue_rd_q;
    logic [1:0]       issue_rs1_q;
    logic [1:0]       issue_rs2_q;
    logic             done_q;
    logic [CNT_W-1:0] stall_q;

    // Field decode of the presented instruction.
    op_e        op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;

    assign op  = op_e'(instr[7:6]);
    assign rd  = instr[5:4];
    assign rs1 = instr[3:2];
    assign rs2 = instr[1:0];

    logic [3:0] pending;
    logic       hazard;
    logic       fire;
    logic       fire_issue;
    logic       fire_halt;
    logic       all_clear;

    // A register is pending while its countdown is nonzero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    // Hazard check against the registered scoreboard for the presented opcode.
    always_comb begin
        // NOTE: default first so every path assigns hazard and no latch is inferred.
        hazard = 1'b0;
        case (op)
            OP_ADD, OP_SUB: hazard = pending[rs1] | pending[rs2] | pending[rd];
            OP_LOAD:        hazard = pending[rs1] | pending[rd];
            default:        hazard = 1'b0;
        endcase
    end

    assign instr_ready = (state_q == ST_RUN) && !hazard;
    assign fire        = instr_valid && instr_ready;
    assign fire_issue  = fire && (op != OP_HALT);
    assign fire_halt   = fire && (op == OP_HALT);
    assign all_clear   = (pending == 4'b0000);

    // Scoreboard next state: count down, a newly issued writer reloads its entry.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = pending[i] ? (cnt_q[i] - SB_W'(1)) : cnt_q[i];
            if (fire_issue && (rd == 2'(i))) begin
                cnt_d[i] = (op == OP_LOAD) ? LOAD_CNT : ALU_CNT;
            end
        end
    end

    // Run-control FSM, scoreboard, issue register, done pulse and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            // NOTE: the scoreboard array is reset explicitly; stale countdowns would
            // otherwise raise false hazards on the first run after reset.
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_op_q    <= 2'b00;
            issue_rd_q    <= 2'b00;
            issue_rs1_q   <= 2'b00;
            issue_rs2_q   <= 2'b00;
            done_q        <= 1'b0;
            stall_q       <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end

            issue_valid_q <= fire_issue;
            if (fire_issue) begin
                issue_op_q  <= instr[7:6];
                issue_rd_q  <= rd;
                issue_rs1_q <= rs1;
                issue_rs2_q <= rs2;
            end

            if ((state_q == ST_RUN) && instr_valid && hazard && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end

            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire_halt) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (all_clear) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_op     = issue_op_q;
    assign issue_rd     = issue_rd_q;
    assign issue_rs1    = issue_rs1_q;
    assign issue_rs2    = issue_rs2_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign stall_cycles = stall_q;

endmodule
